// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics datapath: rasterizer coordinate widths,
// default screen size, pixel entry layout and write-FSM state encoding.
package gfx_pkg;

  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int COLOR_W_DEF = 8;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } wr_state_e;

  // Canonical queue entry layout at the default colour width.
  typedef struct packed {
    logic                   last;
    logic [COLOR_W_DEF-1:0] color;
    logic [Y_W-1:0]         y;
    logic [X_W-1:0]         x;
  } pixel_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is accepted only
// when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 28
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Takes the rasterizer pixel stream, drops off-screen and repeated pixels,
// queues the rest and writes them to the linear framebuffer one at a time.
module fb_pixel_writer
  import gfx_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [X_W-1:0]     in_x,
  input  logic [Y_W-1:0]     in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_last,
  output logic               in_ready,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ack,
  output logic               busy,
  output logic               done,
  output logic [15:0]        clip_count
);

  typedef struct packed {
    logic               last;
    logic [COLOR_W-1:0] color;
    logic [Y_W-1:0]     y;
    logic [X_W-1:0]     x;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic               ready_q;
  logic               dup_valid_q, dup_valid_d;
  logic [X_W-1:0]     dup_x_q, dup_x_d;
  logic [Y_W-1:0]     dup_y_q, dup_y_d;
  logic [15:0]        clip_count_q, clip_count_d;
  logic               last_pending_q, last_pending_d;
  logic               s1_valid_q, s1_valid_d;
  entry_t             s1_entry_q, s1_entry_d;
  wr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               last_flag_q, last_flag_d;
  logic               done_q, done_d;

  logic               fifo_full, fifo_empty, fifo_pop, s1_push;
  entry_t             fifo_head;
  logic               accept, is_clip, is_dup, keep;
  logic               drained, fire_pending, ack_last;

  assign in_ready   = ready_q && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign is_clip    = (int'(in_x) >= H_RES) || (int'(in_y) >= V_RES);
  assign is_dup     = dup_valid_q && (in_x == dup_x_q) && (in_y == dup_y_q);
  assign keep       = !is_clip && !is_dup;

  assign mem_req    = (state_q == ST_REQ);
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign done       = done_q;
  assign clip_count = clip_count_q;
  assign busy       = !fifo_empty || mem_req || s1_valid_q;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (s1_push),
    .wdata_i (s1_entry_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Filter stage: the clip/duplicate decision is made at accept time, so only
  // surviving pixels ever occupy the stage register.
  always_comb begin
    s1_push        = s1_valid_q && (!fifo_full || fifo_pop);
    s1_valid_d     = s1_valid_q && !s1_push;
    s1_entry_d     = s1_entry_q;
    dup_valid_d    = dup_valid_q;
    dup_x_d        = dup_x_q;
    dup_y_d        = dup_y_q;
    clip_count_d   = clip_count_q;
    if (accept) begin
      dup_x_d     = in_x;
      dup_y_d     = in_y;
      dup_valid_d = !in_last;
      if (is_clip && (clip_count_q != 16'hFFFF)) clip_count_d = clip_count_q + 16'd1;
      if (keep) begin
        s1_valid_d = 1'b1;
        s1_entry_d = '{last: in_last, color: in_color, y: in_y, x: in_x};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    last_flag_d = last_flag_q;
    if ((state_q == ST_IDLE) || mem_ack) begin
      if (!fifo_empty) begin
        fifo_pop    = 1'b1;
        state_d     = ST_REQ;
        addr_d      = ADDR_W'(fifo_head.y) * ADDR_W'(H_RES) + ADDR_W'(fifo_head.x);
        data_d      = fifo_head.color;
        last_flag_d = fifo_head.last;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // A discarded last beat completes once nothing older is left in flight.
  always_comb begin
    ack_last       = (state_q == ST_REQ) && mem_ack && last_flag_q;
    drained        = !s1_valid_q && fifo_empty && ((state_q == ST_IDLE) || mem_ack);
    fire_pending   = last_pending_q && drained;
    last_pending_d = (last_pending_q && !fire_pending) || (accept && in_last && !keep);
    done_d         = ack_last || fire_pending;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q        <= 1'b0;
      dup_valid_q    <= 1'b0;
      dup_x_q        <= '0;
      dup_y_q        <= '0;
      clip_count_q   <= '0;
      last_pending_q <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_entry_q     <= '0;
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      last_flag_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      ready_q        <= 1'b1;
      dup_valid_q    <= dup_valid_d;
      dup_x_q        <= dup_x_d;
      dup_y_q        <= dup_y_d;
      clip_count_q   <= clip_count_d;
      last_pending_q <= last_pending_d;
      s1_valid_q     <= s1_valid_d;
      s1_entry_q     <= s1_entry_d;
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      last_flag_q    <= last_flag_d;
      done_q         <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: line writes, duplicate hold, clipping,
// memory backpressure, clipped final pixel and asynchronous reset mid-stall.
module tb_fb_pixel_writer;
  import gfx_pkg::*;

  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [X_W-1:0]     in_x = '0;
  logic [Y_W-1:0]     in_y = '0;
  logic [COLOR_W-1:0] in_color = '0;
  logic               in_last = 1'b0;
  logic               in_ready;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic               mem_ack = 1'b0;
  logic               busy;
  logic               done;
  logic [15:0]        clip_count;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int rise_q[$];
  int done_count = 0;
  int done_cycle = -1;
  bit prev_req = 1'b0;

  fb_pixel_writer #(
    .H_RES(640), .V_RES(480), .FIFO_DEPTH(8), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_color(in_color), .in_last(in_last), .in_ready(in_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .busy(busy), .done(done), .clip_count(clip_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Log handshakes, request rises and done pulses at the falling edge.
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(int'(mem_data));
      wc_q.push_back(cycle);
    end
    if (mem_req && !prev_req) rise_q.push_back(cycle);
    prev_req = mem_req;
    if (done) begin
      done_count++;
      done_cycle = cycle;
    end
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    rise_q.delete();
    done_count = 0;
    done_cycle = -1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    mem_ack  = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_log();
  endtask

  task automatic send_beat(input int x, input int y, input int c, input bit last);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_x     = X_W'(x);
    in_y     = Y_W'(y);
    in_color = COLOR_W'(c);
    in_last  = last;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout x=%0d y=%0d: in_ready never 1, required 1", x, y);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: busy stayed 1, required 0");
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL rst_mem_addr got %0d exp 0", mem_addr); end
    checks++; if (mem_data !== '0) begin errors++; $display("[TB] FAIL rst_mem_data got %0d exp 0", mem_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy); end
    checks++; if (clip_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_clip got %0d exp 0", clip_count); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready_pre got %b exp 0", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready_post got %b exp 1", in_ready); end
  endtask

  task automatic test_hline();
    int acc0;
    apply_reset();
    mem_ack = 1'b1;
    acc0 = 0;
    for (int x = 10; x <= 20; x++) begin
      send_beat(x, 20, 8'h3C, x == 20);
      if (x == 10) acc0 = cycle;
    end
    wait_idle();
    checks++;
    if (rise_q.size() < 1 || rise_q[0] != acc0 + 2) begin
      errors++;
      $display("[TB] FAIL hline_latency got %0d exp %0d", (rise_q.size() > 0) ? rise_q[0] : -1, acc0 + 2);
    end
    checks++;
    if (wa_q.size() != 11) begin
      errors++;
      $display("[TB] FAIL hline_count got %0d exp 11", wa_q.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (wa_q[i] != 12810 + i || wd_q[i] != 8'h3C) begin
          errors++;
          $display("[TB] FAIL hline_write[%0d] got addr %0d data %0h exp addr %0d data 3c", i, wa_q[i], wd_q[i], 12810 + i);
        end
      end
      checks++;
      if (done_count != 1 || done_cycle != wc_q[10] + 1) begin
        errors++;
        $display("[TB] FAIL hline_done got count %0d cycle %0d exp count 1 cycle %0d", done_count, done_cycle, wc_q[10] + 1);
      end
    end
  endtask

  task automatic test_hold();
    apply_reset();
    mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) send_beat(20, 20, 8'h55, k == 4);
    wait_idle();
    checks++;
    if (wa_q.size() != 1 || wa_q[0] != 12820 || wd_q[0] != 8'h55) begin
      errors++;
      $display("[TB] FAIL hold_write got count %0d addr %0d exp count 1 addr 12820", wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1);
    end
    checks++;
    if (done_count != 1) begin errors++; $display("[TB] FAIL hold_done got %0d exp 1", done_count); end
  endtask

  task automatic test_clip();
    apply_reset();
    mem_ack = 1'b1;
    send_beat(639, 479, 8'h11, 1'b0);
    send_beat(640, 0, 8'h22, 1'b0);
    send_beat(0, 480, 8'h33, 1'b1);
    wait_idle();
    checks++;
    if (wa_q.size() != 1 || wa_q[0] != 307199 || wd_q[0] != 8'h11) begin
      errors++;
      $display("[TB] FAIL clip_write got count %0d addr %0d exp count 1 addr 307199", wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1);
    end
    checks++;
    if (clip_count !== 16'd2) begin errors++; $display("[TB] FAIL clip_count got %0d exp 2", clip_count); end
    checks++;
    if (done_count != 1) begin errors++; $display("[TB] FAIL clip_done got %0d exp 1", done_count); end
  endtask

  task automatic test_backpressure();
    int  idx;
    int  first_addr;
    int  first_data;
    bit  stable_ok;
    bit  fire;
    apply_reset();
    mem_ack    = 1'b0;
    idx        = 0;
    first_addr = -1;
    first_data = -1;
    stable_ok  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (idx < 12) begin
        in_valid = 1'b1;
        in_x     = X_W'(100 + idx);
        in_y     = Y_W'(50);
        in_color = COLOR_W'(idx + 1);
        in_last  = (idx == 11);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      fire = in_valid && in_ready;
      if (mem_req) begin
        if (first_addr < 0) begin
          first_addr = int'(mem_addr);
          first_data = int'(mem_data);
        end else if (int'(mem_addr) != first_addr || int'(mem_data) != first_data) begin
          stable_ok = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (fire) idx++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    checks++; if (idx != 10) begin errors++; $display("[TB] FAIL bp_accepted got %0d exp 10", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready got %b exp 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy got %b exp 1", busy); end
    checks++;
    if (!stable_ok || first_addr != 32100 || first_data != 1) begin
      errors++;
      $display("[TB] FAIL bp_stable got addr %0d data %0d stable %b exp addr 32100 data 1 stable 1", first_addr, first_data, stable_ok);
    end
    mem_ack = 1'b1;
    while (idx < 12) begin
      send_beat(100 + idx, 50, idx + 1, idx == 11);
      idx++;
    end
    wait_idle();
    checks++;
    if (wa_q.size() != 12) begin
      errors++;
      $display("[TB] FAIL bp_count got %0d exp 12", wa_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (wa_q[i] != 32100 + i || wd_q[i] != i + 1) begin
          errors++;
          $display("[TB] FAIL bp_order[%0d] got addr %0d data %0d exp addr %0d data %0d", i, wa_q[i], wd_q[i], 32100 + i, i + 1);
        end
      end
    end
    checks++;
    if (done_count != 1) begin errors++; $display("[TB] FAIL bp_done got %0d exp 1", done_count); end
  endtask

  task automatic test_last_clipped();
    apply_reset();
    mem_ack = 1'b1;
    send_beat(5, 5, 8'h77, 1'b0);
    send_beat(700, 5, 8'h78, 1'b1);
    wait_idle();
    checks++;
    if (wa_q.size() != 1 || wa_q[0] != 3205 || wd_q[0] != 8'h77) begin
      errors++;
      $display("[TB] FAIL lastclip_write got count %0d addr %0d exp count 1 addr 3205", wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1);
    end else begin
      checks++;
      if (done_count != 1 || done_cycle != wc_q[0] + 1) begin
        errors++;
        $display("[TB] FAIL lastclip_done got count %0d cycle %0d exp count 1 cycle %0d", done_count, done_cycle, wc_q[0] + 1);
      end
    end
    checks++;
    if (clip_count !== 16'd1) begin errors++; $display("[TB] FAIL lastclip_count got %0d exp 1", clip_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) send_beat(200 + k, 100, 8'h40 + k, k == 4);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre got req %b busy %b exp req 1 busy 1", mem_req, busy);
    end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b exp 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    mem_ack = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (wa_q.size() != 0) begin errors++; $display("[TB] FAIL midrst_stale got %0d writes exp 0", wa_q.size()); end
    checks++; if (done_count != 0) begin errors++; $display("[TB] FAIL midrst_done got %0d exp 0", done_count); end
  endtask

  initial begin
    $display("[TB] fb_pixel_writer directed tests");
    test_reset();
    test_hline();
    test_hold();
    test_clip();
    test_backpressure();
    test_last_clipped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Downstream of the Bresenham line rasterizer: consumes the (X,Y) pixel stream it produces and writes each pixel into the linear framebuffer through a single-port request/acknowledge memory interface.
- Clips off-screen pixels and drops consecutive duplicates (the rasterizer holds its last coordinate after finishing).
- Buffers pixels in a small FIFO so rasterizer stepping is decoupled from memory latency.
- Signals completion once the final pixel of a primitive has been committed.

Parameters:
- H_RES, 640, visible pixels per row; valid x range 0..H_RES-1.
- V_RES, 480, visible rows; valid y range 0..V_RES-1.
- FIFO_DEPTH, 8, pixel FIFO entries; must be a power of two, at least 2.
- ADDR_W, 19, framebuffer word address width; must hold H_RES*V_RES-1.
- COLOR_W, 8, pixel colour width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel present on in_x/in_y/in_color.
- in_x  in  10  pixel column (rasterizer X).
- in_y  in  9  pixel row (rasterizer Y).
- in_color  in  COLOR_W  pixel colour.
- in_last  in  1  this beat is the final pixel of the primitive.
- in_ready  out  1  block can accept a beat this cycle.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  word address, computed as y*H_RES+x.
- mem_data  out  COLOR_W  write data.
- mem_ack  in  1  memory accepted the current request.
- busy  out  1  FIFO non-empty or a request is outstanding.
- done  out  1  one-cycle pulse when a primitive's last pixel is committed.
- clip_count  out  16  saturating count of clipped pixels since reset.

Behaviour:
- Reset (async, active-high): FIFO empty; mem_req=0, mem_addr=0, mem_data=0; done=0, clip_count=0, busy=0; in_ready=1 after the first clock edge following reset release; duplicate register invalidated; last_pending=0.
- Accept: a beat is taken when in_valid && in_ready. in_ready = !fifo_full.
- Stage 1, filter (registered): an accepted beat is discarded without entering the FIFO when:
  - it is clipped (in_x>=H_RES or in_y>=V_RES); clip_count increments, saturating at 16'hFFFF; or
  - it is a duplicate (in_x,in_y equal to the previous accepted beat, and the duplicate register is valid). Duplicates are not counted.
  - Otherwise the beat enters the FIFO.
  - The duplicate register updates on every accepted beat, clipped or not, and is invalidated after any in_last beat.
- Last-pixel handling: if an in_last beat is discarded, last_pending is still set so that done fires once the FIFO drains and any outstanding write completes. An in_last beat that enters the FIFO carries a last flag in its entry.
- Stage 2, address: mem_addr = y*H_RES+x, computed at FIFO read time and registered with the request, so address/data are stable while mem_req=1.
- Memory FSM:
  - IDLE: if FIFO non-empty, pop the head, load mem_addr/mem_data, mem_req=1, go to REQ.
  - REQ: hold mem_req, mem_addr and mem_data until mem_ack=1. On ack:
    - if the entry's last flag is set, pulse done next cycle;
    - if FIFO non-empty, pop the next entry and stay in REQ with mem_req held at 1 (back-to-back, one write per cycle at best);
    - else deassert mem_req and go to IDLE.
  - mem_ack while mem_req=0 is ignored.
- Latency: accepted beat to mem_req=1 is 2 cycles when the FIFO is empty and the FSM is IDLE.
- Simultaneous events:
  - FIFO push and pop in the same cycle is legal when full; in_ready is computed from pre-pop state (conservative).
  - If last_pending and the FSM's last ack coincide, done is a single pulse.
- busy = fifo_nonempty | mem_req | stage-1 occupied.
- Reset mid-operation discards all queued pixels; no done pulse is issued.

Decomposition:
- Shared package gfx_pkg: H_RES/V_RES defaults, the X width of 10 and Y width of 9 (matching the rasterizer outputs), the pixel entry typedef {last, color, y, x}, and the FSM state encoding.
- One sub-module: pixel_fifo, a synchronous FIFO with full/empty flags, parameterised by depth and entry width, using the same async reset.

Test Plan:
- Horizontal line x=10..20 at y=20, colour 8'h3C, in_last on x=20, mem_ack always 1 -> 11 writes, addresses 12810..12820; done pulses once, 1 cycle after the ack for address 12820.
- Rasterizer hold: pixel (20,20) presented 5 times, the final beat with in_last -> exactly one write to 12820; done still pulses.
- Clip: pixels (639,479), (640,0), (0,480) -> single write to addr 307199; clip_count=2.
- Backpressure: mem_ack held 0 for 20 cycles while 12 distinct pixels are offered -> in_ready falls after 8 FIFO entries plus the pipeline; no beat lost; writes emerge in order once ack is asserted; mem_addr stable while mem_req=1 and stalled.
- Last pixel clipped: pixels (5,5), then (700,5) with in_last -> one write to 3205; done pulses after its ack; clip_count=1.
- Async reset asserted mid-stall with 4 entries queued -> mem_req drops immediately without waiting for a clock edge; busy=0; after release, no stale writes and no done pulse.
